// File: rtl/jesd_tx_transport_pkg.sv
// Shared constants, register map and sample helpers for the JESD TX transport front end.
package jesd_tx_transport_pkg;

    localparam int SAMPLE_W         = 16;
    localparam int SAMPLES_PER_WORD = 8;
    localparam int WORD_W           = SAMPLE_W * SAMPLES_PER_WORD;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4A54_4E31;

    // Register indices as seen on addr[4:2]
    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_PATTERN   = 3'd1;
    localparam logic [2:0] REG_STATUS    = 3'd2;
    localparam logic [2:0] REG_UNDERFLOW = 3'd3;
    localparam logic [2:0] REG_ID        = 3'd4;

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'd0,
        MODE_STREAM  = 2'd1,
        MODE_PATTERN = 2'd2,
        MODE_RAMP    = 2'd3
    } mode_e;

    function automatic logic [WORD_W-1:0] swap_bytes(input logic [WORD_W-1:0] d);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int k = 0; k < SAMPLES_PER_WORD; k++)
            r[k*SAMPLE_W +: SAMPLE_W] = {d[k*SAMPLE_W +: 8], d[k*SAMPLE_W+8 +: 8]};
        return r;
    endfunction

endpackage

// File: rtl/jesd_tx_fifo.sv
// Show-ahead synchronous FIFO with level, single-cycle flush, and push-on-full when popping.
module jesd_tx_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd];

    assign w_pop  = i_pop && !o_empty && !i_flush;
    assign w_push = i_push && !i_flush && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

endmodule

// File: rtl/jesd_tx_transport.sv
// JESD TX transport front end: AXI-Lite control, AXIS sample buffer and per-beat word
// generation (idle / stream / pattern / ramp) with optional per-sample byte swap.
module jesd_tx_transport
    import jesd_tx_transport_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] ID_VALUE   = ID_VALUE_DEFAULT
) (
    input  logic          s_axil_aclk,
    input  logic          s_axil_aresetn,
    input  logic [31:0]   s_axil_awaddr,
    input  logic [2:0]    s_axil_awprot,
    input  logic          s_axil_awvalid,
    output logic          s_axil_awready,
    input  logic [31:0]   s_axil_wdata,
    input  logic [3:0]    s_axil_wstrb,
    input  logic          s_axil_wvalid,
    output logic          s_axil_wready,
    output logic [1:0]    s_axil_bresp,
    output logic          s_axil_bvalid,
    input  logic          s_axil_bready,
    input  logic [31:0]   s_axil_araddr,
    input  logic [2:0]    s_axil_arprot,
    input  logic          s_axil_arvalid,
    output logic          s_axil_arready,
    output logic [31:0]   s_axil_rdata,
    output logic [1:0]    s_axil_rresp,
    output logic          s_axil_rvalid,
    input  logic          s_axil_rready,
    input  logic [127:0]  s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    output logic [127:0]  tx_tdata,
    input  logic          tx_tready
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                 r_up;
    logic                 r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic                 r_aw_held, r_w_held;
    logic [2:0]           r_aw_idx;
    logic [15:0]          r_wdata;
    logic [1:0]           r_wstrb;
    logic [31:0]          r_rdata;
    mode_e                r_mode;
    logic                 r_swap;
    logic                 r_flush;
    logic [SAMPLE_W-1:0]  r_pattern;
    logic [31:0]          r_underflow;
    logic [SAMPLE_W-1:0]  r_ramp_cnt;
    logic [WORD_W-1:0]    r_tx_tdata;

    logic                 w_wr_commit;
    logic                 w_ramp_entry;
    logic [31:0]          w_rd_data;
    logic [31:0]          w_status;
    logic [WORD_W-1:0]    w_fifo_head;
    logic [WORD_W-1:0]    w_ramp_word;
    logic [WORD_W-1:0]    w_next;
    logic [LW-1:0]        w_level;
    logic                 w_full, w_empty;
    logic                 w_push, w_pop, w_stream_beat, w_underflow;
    logic                 w_unused;

    assign w_unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[31:5], s_axil_awaddr[1:0],
                        s_axil_araddr[31:5], s_axil_araddr[1:0], s_axil_wdata[31:16],
                        s_axil_wstrb[3:2]};

    assign s_axil_awready = r_awready;
    assign s_axil_wready  = r_wready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_arready = r_arready;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = 2'b00;
    assign tx_tdata       = r_tx_tdata;

    // r_up keeps tready low through reset and raises it on the first clock after release
    assign s_axis_tready = r_up && !w_full && !r_flush;
    assign w_push        = s_axis_tvalid && s_axis_tready;

    assign w_wr_commit  = r_aw_held && r_w_held && !r_bvalid;
    assign w_ramp_entry = w_wr_commit && (r_aw_idx == REG_CTRL) && r_wstrb[0] &&
                          (r_wdata[1:0] == MODE_RAMP) && (r_mode != MODE_RAMP);

    always_comb begin
        w_status          = '0;
        w_status[LW-1:0]  = w_level;
        w_status[8]       = w_empty;
        w_status[9]       = w_full;
    end

    always_comb begin
        w_rd_data = '0;
        case (s_axil_araddr[4:2])
            REG_CTRL:      w_rd_data = {29'd0, r_swap, r_mode};
            REG_PATTERN:   w_rd_data = {16'd0, r_pattern};
            REG_STATUS:    w_rd_data = w_status;
            REG_UNDERFLOW: w_rd_data = r_underflow;
            REG_ID:        w_rd_data = ID_VALUE;
            default:       w_rd_data = '0;
        endcase
    end

    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            r_up      <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_mode    <= MODE_IDLE;
            r_swap    <= 1'b0;
            r_flush   <= 1'b0;
            r_pattern <= '0;
        end else begin
            r_up      <= 1'b1;
            r_flush   <= 1'b0;
            r_awready <= s_axil_awvalid && !r_aw_held && !r_awready && !r_bvalid;
            r_wready  <= s_axil_wvalid && !r_w_held && !r_wready && !r_bvalid;
            if (s_axil_awvalid && r_awready) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s_axil_awaddr[4:2];
            end
            if (s_axil_wvalid && r_wready) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axil_wdata[15:0];
                r_wstrb  <= s_axil_wstrb[1:0];
            end
            if (w_wr_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                case (r_aw_idx)
                    REG_CTRL: if (r_wstrb[0]) begin
                        r_mode  <= mode_e'(r_wdata[1:0]);
                        r_swap  <= r_wdata[2];
                        r_flush <= r_wdata[3];
                    end
                    REG_PATTERN: begin
                        if (r_wstrb[0]) r_pattern[7:0]  <= r_wdata[7:0];
                        if (r_wstrb[1]) r_pattern[15:8] <= r_wdata[15:8];
                    end
                    default: ;
                endcase
            end else if (r_bvalid && s_axil_bready) begin
                r_bvalid <= 1'b0;
            end
            r_arready <= s_axil_arvalid && !r_arready && !r_rvalid;
            if (s_axil_arvalid && r_arready) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (r_rvalid && s_axil_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // A flush cycle behaves as an empty FIFO for the stream source
    assign w_stream_beat = tx_tready && (r_mode == MODE_STREAM);
    assign w_pop         = w_stream_beat && !w_empty && !r_flush;
    assign w_underflow   = w_stream_beat && !w_pop;

    always_comb begin
        w_ramp_word = '0;
        for (int k = 0; k < SAMPLES_PER_WORD; k++)
            w_ramp_word[k*SAMPLE_W +: SAMPLE_W] = r_ramp_cnt + SAMPLE_W'(k);
        w_next = '0;
        case (r_mode)
            MODE_STREAM:  w_next = w_pop ? w_fifo_head : '0;
            MODE_PATTERN: w_next = {SAMPLES_PER_WORD{r_pattern}};
            MODE_RAMP:    w_next = w_ramp_word;
            default:      w_next = '0;
        endcase
    end

    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            r_tx_tdata  <= '0;
            r_ramp_cnt  <= '0;
            r_underflow <= '0;
        end else begin
            if (tx_tready)
                r_tx_tdata <= r_swap ? swap_bytes(w_next) : w_next;
            if (w_ramp_entry)
                r_ramp_cnt <= '0;
            else if (tx_tready && (r_mode == MODE_RAMP))
                r_ramp_cnt <= r_ramp_cnt + SAMPLE_W'(SAMPLES_PER_WORD);
            if (w_wr_commit && (r_aw_idx == REG_UNDERFLOW))
                r_underflow <= '0;
            else if (w_underflow && (r_underflow != '1))
                r_underflow <= r_underflow + 32'd1;
        end
    end

    jesd_tx_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (s_axil_aclk),
        .rst_n   (s_axil_aresetn),
        .i_push  (w_push),
        .i_data  (s_axis_tdata),
        .i_pop   (w_pop),
        .i_flush (r_flush),
        .o_data  (w_fifo_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_jesd_tx_transport.sv
// Scoreboard bench for jesd_tx_transport: directed AXI-Lite/AXIS stimulus, queued
// expectations, and independent monitors for tx_tdata beats and register reads.
module tb_jesd_tx_transport;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]    wstrb = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic          bready = 1'b1, rready = 1'b1;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic [127:0]  tdata = '0;
    logic          tvalid = 1'b0, tready;
    logic [127:0]  tx_tdata;
    logic          tx_tready = 1'b0;
    logic          chk_tx = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic [31:0] addr; logic [31:0] data; } rd_exp_t;
    logic [127:0] exp_tx[$];
    rd_exp_t      exp_rd[$];
    logic [127:0] q_words[$];

    always #5 clk = ~clk;

    jesd_tx_transport dut (
        .s_axil_aclk(clk), .s_axil_aresetn(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .tx_tdata(tx_tdata), .tx_tready(tx_tready)
    );

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [127:0] rep(input logic [15:0] s);
        return {8{s}};
    endfunction

    function automatic logic [127:0] ramp(input logic [15:0] c, input bit sw);
        logic [127:0] r;
        logic [15:0]  s;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            s = c + 16'(k);
            r[16*k +: 16] = sw ? {s[7:0], s[15:8]} : s;
        end
        return r;
    endfunction

    function automatic logic [127:0] mkw(input int i);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 8; k++)
            r[16*k +: 16] = {8'(i), 8'(k)} ^ 16'h5A00;
        return r;
    endfunction

    // tx monitor: every accepted beat must match the next queued word
    initial begin
        logic beat;
        forever begin
            @(posedge clk);
            beat = tx_tready && chk_tx && rst_n;
            @(negedge clk);
            if (beat) begin
                if (exp_tx.size() == 0) check("tx_unexpected_beat", 128'(exp_tx.size()), 128'd1);
                else check("tx_tdata", tx_tdata, exp_tx.pop_front());
            end
        end
    end

    // read monitor: each rvalid&&rready is one completed read
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (rvalid && rready) begin
                if (exp_rd.size() == 0) check("rd_unexpected", 128'(rdata), 128'hX);
                else begin
                    e = exp_rd.pop_front();
                    check($sformatf("rdata@%0h", e.addr), 128'(rdata), 128'(e.data));
                    check("rresp", 128'(rresp), 128'd0);
                end
            end
        end
    end

    task automatic axil_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_hs = 0, w_hs = 0;
        int n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while ((awvalid || wvalid) && n < 20) begin
            @(negedge clk); n++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            if (awvalid && awready) aw_hs = 1;
            if (wvalid && wready)   w_hs  = 1;
        end
        if (awvalid || wvalid) begin
            check("aw_w_accept", 128'({awvalid, wvalid}), 128'd0);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        check("bvalid", 128'(bvalid), 128'd1);
        check("bresp", 128'(bresp), 128'd0);
        @(negedge clk);
    endtask

    task automatic axil_read(input logic [31:0] a, input logic [31:0] e);
        int n = 0;
        exp_rd.push_back('{a, e});
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (!arready) begin
            check("arready", 128'(arready), 128'd1);
            void'(exp_rd.pop_back());
            arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
    endtask

    task automatic beats(input int n);
        @(negedge clk);
        tx_tready = 1'b1; chk_tx = 1'b1;
        repeat (n) @(negedge clk);
        tx_tready = 1'b0; chk_tx = 1'b0;
    endtask

    task automatic axis_push(input logic [127:0] d);
        int n = 0;
        tdata = d; tvalid = 1'b1;
        while (!tready && n < 50) begin @(negedge clk); n++; end
        if (!tready) check("axis_tready_wait", 128'(tready), 128'd1);
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_axil_outs", 128'({awready, wready, bvalid, arready, rvalid}), 128'd0);
        check("rst_axis_tready", 128'(tready), 128'd0);
        check("rst_tx_tdata", tx_tdata, 128'd0);
        check("rst_rdata", 128'(rdata), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("tready_after_rst", 128'(tready), 128'd1);

        axil_read(32'h10, 32'h4A54_4E31);
        axil_read(32'h08, 32'h0000_0100);
        axil_read(32'h00, 32'h0);
        axil_read(32'h0C, 32'h0);
        axil_read(32'h14, 32'h0);

        repeat (3) exp_tx.push_back(128'd0);
        beats(3);

        // pattern, then swapped pattern
        axil_write(32'h04, 32'h0000_1234, 4'hF);
        axil_write(32'h00, 32'h2, 4'hF);
        repeat (4) exp_tx.push_back(rep(16'h1234));
        beats(4);
        axil_write(32'h00, 32'h6, 4'hF);
        repeat (3) exp_tx.push_back(rep(16'h3412));
        beats(3);
        axil_read(32'h00, 32'h6);

        // byte strobes, ignored writes
        axil_write(32'h04, 32'hABCD_5678, 4'b0001);
        axil_write(32'h00, 32'h2, 4'hF);
        axil_write(32'h00, 32'h3, 4'b0000);
        axil_read(32'h04, 32'h0000_1278);
        axil_read(32'h00, 32'h2);
        repeat (2) exp_tx.push_back(rep(16'h1278));
        beats(2);
        axil_write(32'h14, 32'hFFFF_FFFF, 4'hF);
        axil_read(32'h14, 32'h0);

        // fill the FIFO with the link stalled, then drain in order
        axil_write(32'h00, 32'h1, 4'hF);
        for (int i = 0; i < 16; i++) axis_push(mkw(i));
        check("full_axis_tready", 128'(tready), 128'd0);
        axil_read(32'h08, 32'h0000_0210);
        for (int i = 0; i < 16; i++) exp_tx.push_back(mkw(i));
        beats(16);
        axil_read(32'h08, 32'h0000_0100);
        axil_read(32'h0C, 32'h0);

        // underflow counting and clear-on-write
        repeat (5) exp_tx.push_back(128'd0);
        beats(5);
        axil_read(32'h0C, 32'd5);
        axil_write(32'h0C, 32'h1234_5678, 4'h0);
        axil_read(32'h0C, 32'd0);

        // push and pop on an empty FIFO: underflow, word kept for next beat
        exp_tx.push_back(128'd0);
        exp_tx.push_back(mkw(99));
        @(negedge clk);
        tdata = mkw(99); tvalid = 1'b1; tx_tready = 1'b1; chk_tx = 1'b1;
        @(negedge clk);
        tvalid = 1'b0;
        @(negedge clk);
        tx_tready = 1'b0; chk_tx = 1'b0;
        axil_read(32'h0C, 32'd1);
        axil_read(32'h08, 32'h0000_0100);

        // ramp across the 16-bit wrap
        axil_write(32'h00, 32'h3, 4'hF);
        for (int i = 0; i < 8194; i++) exp_tx.push_back(ramp(16'(i * 8), 1'b0));
        beats(8194);

        // re-entry restarts the ramp; swap applies to it
        axil_write(32'h00, 32'h1, 4'hF);
        axil_write(32'h00, 32'h7, 4'hF);
        for (int i = 0; i < 3; i++) exp_tx.push_back(ramp(16'(i * 8), 1'b1));
        beats(3);

        // flush
        axil_write(32'h00, 32'h0, 4'hF);
        axil_write(32'h0C, 32'h0, 4'hF);
        for (int i = 0; i < 10; i++) axis_push(mkw(50 + i));
        axil_read(32'h08, 32'h0000_000A);
        axil_write(32'h00, 32'h9, 4'hF);
        axil_read(32'h08, 32'h0000_0100);
        axil_read(32'h00, 32'h1);
        repeat (3) exp_tx.push_back(128'd0);
        beats(3);
        axil_read(32'h0C, 32'd3);

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) axis_push(mkw(70 + i));
        tx_tready = 1'b1;
        repeat (2) @(negedge clk);
        tx_tready = 1'b0;
        check("pre_rst_tx", tx_tdata, mkw(71));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx_tdata, 128'd0);
        check("async_rst_tready", 128'(tready), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        axil_read(32'h08, 32'h0000_0100);
        axil_read(32'h00, 32'h0);
        axil_read(32'h0C, 32'h0);

        repeat (3) @(negedge clk);
        check("tx_queue_drained", 128'(exp_tx.size()), 128'd0);
        check("rd_queue_drained", 128'(exp_rd.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
